traffic_light_ctrl: RTL and testbench

Downstream consumer of the seconds-countdown timer's serial stream. It deserializes the 8-bit LSB-first countdown frames (values 9..0) and drives a 7-segment digit with the current value. It sequences the RED -> GREEN -> YELLOW -> RED lamp state machine on countdown expiry. A watchdog forces a safe steady-yellow FAULT state if frames stop arriving.

---
 rtl/traffic_light_ctrl.sv | 157 +++++++++++++++
 tb/tb_traffic_light_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl: deserializes LSB-first 8-bit countdown frames, shows the
// current value on a 7-segment digit and steps a RED->GREEN->YELLOW lamp
// sequence each time the countdown expires. A frame watchdog drops the
// controller into a steady-yellow FAULT state when the stream goes quiet.
module traffic_light_ctrl #(
    parameter int RED_LEN    = 2,
    parameter int GREEN_LEN  = 2,
    parameter int YELLOW_LEN = 1,
    parameter int TIMEOUT    = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sin,
    input  logic       sin_vld,
    output logic       red,
    output logic       yellow,
    output logic       green,
    output logic [6:0] seg,
    output logic       frame_err,
    output logic       fault
);

    typedef enum logic [1:0] {S_RED, S_GREEN, S_YELLOW, S_FAULT} state_t;

    state_t      state;
    logic [3:0]  phase;
    logic [2:0]  bitcnt;
    logic [7:0]  shreg;
    logic [15:0] wd;

    logic        frame_done;
    logic [7:0]  frame_val;
    logic        frame_ok;
    logic        wd_expire;
    logic        unused_lsb;

    // The completing bit is still on sin, so the frame is assembled from it
    // plus the seven most recent bits; the oldest shreg bit is shifted out.
    assign frame_done = sin_vld && (bitcnt == 3'd7);
    assign frame_val  = {sin, shreg[7:1]};
    assign frame_ok   = frame_done && (frame_val <= 8'd9);
    // An accepted frame on the expiry edge wins over the watchdog.
    assign wd_expire  = !frame_ok && (wd == 16'(TIMEOUT - 1));
    assign unused_lsb = shreg[0];

    function automatic logic [6:0] seg_decode(input logic [7:0] v);
        case (v)
            8'd0:    return 7'h3F;
            8'd1:    return 7'h06;
            8'd2:    return 7'h5B;
            8'd3:    return 7'h4F;
            8'd4:    return 7'h66;
            8'd5:    return 7'h6D;
            8'd6:    return 7'h7D;
            8'd7:    return 7'h07;
            8'd8:    return 7'h7F;
            8'd9:    return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    function automatic logic [3:0] len_of(input state_t s);
        case (s)
            S_RED:    return 4'(RED_LEN);
            S_GREEN:  return 4'(GREEN_LEN);
            S_YELLOW: return 4'(YELLOW_LEN);
            default:  return 4'd1;
        endcase
    endfunction

    function automatic state_t next_of(input state_t s);
        case (s)
            S_RED:    return S_GREEN;
            S_GREEN:  return S_YELLOW;
            default:  return S_RED;
        endcase
    endfunction

    // Lamp pattern {red, yellow, green}; exactly one bit set per state.
    function automatic logic [2:0] lamps_of(input state_t s);
        case (s)
            S_RED:    return 3'b100;
            S_GREEN:  return 3'b001;
            default:  return 3'b010;
        endcase
    endfunction

    // Shift in serial bits, count frame position and flag aborted or out-of-range frames.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg     <= 8'd0;
            bitcnt    <= 3'd0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (sin_vld) begin
                shreg  <= {sin, shreg[7:1]};
                bitcnt <= bitcnt + 3'd1;
                if (frame_done && !frame_ok)
                    frame_err <= 1'b1;
            end else if (bitcnt != 3'd0) begin
                bitcnt    <= 3'd0;
                frame_err <= 1'b1;
            end
        end
    end

    // Count cycles since the last accepted frame, saturating at TIMEOUT.
    always_ff @(posedge clk) begin
        if (rst)
            wd <= 16'd0;
        else if (frame_ok)
            wd <= 16'd0;
        else if (wd != 16'(TIMEOUT))
            wd <= wd + 16'd1;
    end

    // Lamp state machine with registered lamp, digit and fault outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state                 <= S_RED;
            phase                 <= 4'd0;
            {red, yellow, green}  <= 3'b100;
            seg                   <= 7'h3F;
            fault                 <= 1'b0;
        end else if (frame_ok) begin
            if (state == S_FAULT) begin
                // Only a fresh start of the countdown (value 9) restores service.
                if (frame_val == 8'd9) begin
                    state                <= S_RED;
                    phase                <= 4'd0;
                    {red, yellow, green} <= lamps_of(S_RED);
                    fault                <= 1'b0;
                    seg                  <= seg_decode(frame_val);
                end
            end else begin
                seg <= seg_decode(frame_val);
                if (frame_val == 8'd0) begin
                    if (phase + 4'd1 == len_of(state)) begin
                        state                <= next_of(state);
                        phase                <= 4'd0;
                        {red, yellow, green} <= lamps_of(next_of(state));
                    end else begin
                        phase <= phase + 4'd1;
                    end
                end
            end
        end else if (wd_expire) begin
            state                <= S_FAULT;
            phase                <= 4'd0;
            {red, yellow, green} <= 3'b010;
            fault                <= 1'b1;
            seg                  <= 7'h00;
        end
    end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// tb_traffic_light_ctrl: scoreboard bench for traffic_light_ctrl. A small
// reference model pushes expected {seg, red, yellow, green, fault, frame_err}
// words as stimulus is driven; each test pops and compares at the output edge.
module tb_traffic_light_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       sin;
    logic       sin_vld;
    logic       red;
    logic       yellow;
    logic       green;
    logic [6:0] seg;
    logic       frame_err;
    logic       fault;

    always #5 clk = ~clk;

    traffic_light_ctrl #(
        .RED_LEN(2), .GREEN_LEN(2), .YELLOW_LEN(1), .TIMEOUT(200)
    ) dut (
        .clk(clk), .rst(rst), .sin(sin), .sin_vld(sin_vld),
        .red(red), .yellow(yellow), .green(green), .seg(seg),
        .frame_err(frame_err), .fault(fault)
    );

    int          vectors     = 0;
    int          miscompares = 0;
    logic [11:0] sbq[$];
    logic [11:0] exp_w;
    logic [11:0] observed;
    logic        started = 1'b0;

    assign observed = {seg, red, yellow, green, fault, frame_err};

    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    int len_tab [3] = '{2, 2, 1};

    // Reference model: 0=RED 1=GREEN 2=YELLOW 3=FAULT
    int         m_state;
    int         m_phase;
    logic [6:0] m_seg;

    function automatic logic [2:0] m_lamps(input int s);
        case (s)
            0:       return 3'b100;
            1:       return 3'b001;
            default: return 3'b010;
        endcase
    endfunction

    task automatic model_reset();
        m_state = 0; m_phase = 0; m_seg = 7'h3F;
    endtask

    task automatic model_push(input logic ferr);
        sbq.push_back({m_seg, m_lamps(m_state), (m_state == 3), ferr});
    endtask

    task automatic model_fault();
        m_state = 3; m_phase = 0; m_seg = 7'h00;
    endtask

    task automatic model_frame(input int v);
        if (v <= 9) begin
            if (m_state == 3) begin
                if (v == 9) begin
                    m_state = 0; m_phase = 0; m_seg = seg_tab[9];
                end
            end else begin
                m_seg = seg_tab[v];
                if (v == 0) begin
                    m_phase++;
                    if (m_phase == len_tab[m_state]) begin
                        m_state = (m_state + 1) % 3;
                        m_phase = 0;
                    end
                end
            end
        end
        model_push(v > 9);
    endtask

    // Drive nbits bits of v LSB first; returns 1 time unit after the last edge with sin_vld low.
    task automatic drive_frame(input logic [7:0] v, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            sin = v[i]; sin_vld = 1'b1;
            @(posedge clk); #1;
        end
        sin_vld = 1'b0; sin = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Lamps must stay one-hot on every cycle once the design has been reset.
    always @(negedge clk) begin
        if (started) begin
            vectors++;
            if (!$onehot({red, yellow, green})) begin
                miscompares++;
                $display("FAIL onehot: got ryg=%b want one-hot", {red, yellow, green});
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1; sin = 1'b0; sin_vld = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        model_push(1'b0);
        exp_w = sbq.pop_front(); vectors++;
        if (observed !== exp_w) begin
            miscompares++;
            $display("FAIL reset: got %h want %h", observed, exp_w);
        end
        rst = 1'b0;
        started = 1'b1;
    endtask

    task automatic test_countdown(input int rounds, input string name);
        for (int c = 0; c < rounds; c++) begin
            for (int v = 9; v >= 0; v--) begin
                model_frame(v);
                drive_frame(8'(v), 8);
                exp_w = sbq.pop_front(); vectors++;
                if (observed !== exp_w) begin
                    miscompares++;
                    $display("FAIL %s round %0d v=%0d: got %h want %h", name, c, v, observed, exp_w);
                end
                idle(53);
            end
        end
    endtask

    task automatic test_full_cycle();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        test_countdown(5, "full_cycle");
    endtask

    task automatic test_abort();
        model_push(1'b1);
        drive_frame(8'hA5, 4);
        @(posedge clk); #1;
        exp_w = sbq.pop_front(); vectors++;
        if (observed !== exp_w) begin
            miscompares++;
            $display("FAIL abort_pulse: got %h want %h", observed, exp_w);
        end
        model_push(1'b0);
        @(posedge clk); #1;
        exp_w = sbq.pop_front(); vectors++;
        if (observed !== exp_w) begin
            miscompares++;
            $display("FAIL abort_clear: got %h want %h", observed, exp_w);
        end
        model_frame(7);
        drive_frame(8'd7, 8);
        exp_w = sbq.pop_front(); vectors++;
        if (observed !== exp_w) begin
            miscompares++;
            $display("FAIL abort_next7: got %h want %h", observed, exp_w);
        end
        idle(53);
    endtask

    task automatic test_out_of_range();
        model_frame(12);
        drive_frame(8'd12, 8);
        exp_w = sbq.pop_front(); vectors++;
        if (observed !== exp_w) begin
            miscompares++;
            $display("FAIL range_12: got %h want %h", observed, exp_w);
        end
        model_push(1'b0);
        @(posedge clk); #1;
        exp_w = sbq.pop_front(); vectors++;
        if (observed !== exp_w) begin
            miscompares++;
            $display("FAIL range_clear: got %h want %h", observed, exp_w);
        end
        idle(40);
        model_frame(0);
        drive_frame(8'd0, 8);
        exp_w = sbq.pop_front(); vectors++;
        if (observed !== exp_w) begin
            miscompares++;
            $display("FAIL range_next0: got %h want %h", observed, exp_w);
        end
        idle(53);
    endtask

    task automatic test_watchdog();
        // Frame completing exactly on the would-be expiry edge is accepted.
        model_frame(4);
        drive_frame(8'd4, 8);
        exp_w = sbq.pop_front(); vectors++;
        if (observed !== exp_w) begin
            miscompares++;
            $display("FAIL wd_frame4: got %h want %h", observed, exp_w);
        end
        idle(192);
        model_frame(3);
        drive_frame(8'd3, 8);
        exp_w = sbq.pop_front(); vectors++;
        if (observed !== exp_w) begin
            miscompares++;
            $display("FAIL wd_race: got %h want %h", observed, exp_w);
        end
        idle(199);
        model_push(1'b0);
        exp_w = sbq.pop_front(); vectors++;
        if (observed !== exp_w) begin
            miscompares++;
            $display("FAIL wd_199: got %h want %h", observed, exp_w);
        end
        idle(1);
        model_fault();
        model_push(1'b0);
        exp_w = sbq.pop_front(); vectors++;
        if (observed !== exp_w) begin
            miscompares++;
            $display("FAIL wd_expire: got %h want %h", observed, exp_w);
        end
        idle(10);
        model_frame(5);
        drive_frame(8'd5, 8);
        exp_w = sbq.pop_front(); vectors++;
        if (observed !== exp_w) begin
            miscompares++;
            $display("FAIL fault_frame5: got %h want %h", observed, exp_w);
        end
        idle(10);
        model_frame(9);
        drive_frame(8'd9, 8);
        exp_w = sbq.pop_front(); vectors++;
        if (observed !== exp_w) begin
            miscompares++;
            $display("FAIL fault_exit9: got %h want %h", observed, exp_w);
        end
        idle(53);
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] pre [3] = '{8'd0, 8'd0, 8'd6};
        logic [7:0] part = 8'hB6;
        // Move away from reset-like state first: GREEN showing 6.
        for (int k = 0; k < 3; k++) begin
            model_frame(int'(pre[k]));
            drive_frame(pre[k], 8);
            exp_w = sbq.pop_front(); vectors++;
            if (observed !== exp_w) begin
                miscompares++;
                $display("FAIL prereset_%0d: got %h want %h", k, observed, exp_w);
            end
            idle(53);
        end
        for (int i = 0; i < 5; i++) begin
            sin = part[i]; sin_vld = 1'b1;
            @(posedge clk); #1;
        end
        sin = part[5]; sin_vld = 1'b1; rst = 1'b1;
        model_reset();
        model_push(1'b0);
        @(posedge clk); #1;
        rst = 1'b0; sin_vld = 1'b0; sin = 1'b0;
        exp_w = sbq.pop_front(); vectors++;
        if (observed !== exp_w) begin
            miscompares++;
            $display("FAIL midframe_reset: got %h want %h", observed, exp_w);
        end
        idle(5);
        model_frame(3);
        drive_frame(8'd3, 8);
        exp_w = sbq.pop_front(); vectors++;
        if (observed !== exp_w) begin
            miscompares++;
            $display("FAIL after_reset3: got %h want %h", observed, exp_w);
        end
        idle(20);
        model_frame(0);
        drive_frame(8'd0, 8);
        exp_w = sbq.pop_front(); vectors++;
        if (observed !== exp_w) begin
            miscompares++;
            $display("FAIL after_reset0: got %h want %h", observed, exp_w);
        end
    endtask

    initial begin
        test_reset();
        test_countdown(1, "countdown");
        test_full_cycle();
        test_abort();
        test_out_of_range();
        test_watchdog();
        test_reset_mid_frame();
        idle(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
